// File: rtl/duc_gain_sat_491m.sv
// Post-interpolation gain stage for the 491.52 MHz DUC sample stream.
// Applies a per-carrier Q2.14 gain, then rounds half up and saturates to 16 bits.
// Also counts saturated samples and reports the mean power of fixed-length windows.
module duc_gain_sat_491m #(
  parameter int WIN_LOG2  = 10,
  parameter int SAT_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_data_vld,
  input  logic                  i_data_ca,
  input  logic signed [15:0]    i_data,
  input  logic [15:0]           i_gain_c0,
  input  logic [15:0]           i_gain_c1,
  input  logic                  i_gain_load,
  input  logic                  i_sat_clr,
  output logic                  o_data_vld,
  output logic                  o_data_ca,
  output logic signed [15:0]    o_data,
  output logic [SAT_CNT_W-1:0]  o_sat_cnt,
  output logic [31:0]           o_pwr,
  output logic                  o_pwr_vld
);

  localparam int ACC_W = 31 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0]  CNT_ONE  = WIN_LOG2'(1);
  localparam logic [WIN_LOG2-1:0]  CNT_LAST = {WIN_LOG2{1'b1}};
  localparam logic [SAT_CNT_W-1:0] SAT_MAX  = {SAT_CNT_W{1'b1}};
  localparam logic [SAT_CNT_W-1:0] SAT_ONE  = SAT_CNT_W'(1);

  // Shadow gains
  logic [15:0]        gain_c0_r;
  logic [15:0]        gain_c1_r;
  logic [15:0]        gain_sel_s;

  // Stage 1
  logic               s1_vld_r;
  logic               s1_ca_r;
  logic signed [15:0] s1_data_r;
  logic [15:0]        s1_gain_r;

  // Stage 2
  logic signed [32:0] mult_s;
  logic               s2_vld_r;
  logic               s2_ca_r;
  logic signed [32:0] s2_prod_r;

  // Stage 3 combinational
  logic signed [32:0] round_sum_s;
  logic signed [32:0] rnd_s;
  logic signed [15:0] sat_data_s;
  logic               sat_s;
  logic               sat_hit_s;

  // Power meter
  logic [30:0]          sq_s;
  logic [ACC_W-1:0]     acc_r;
  logic [ACC_W-1:0]     acc_next_s;
  logic [WIN_LOG2-1:0]  win_cnt_r;

  // Shadow gain registers; a load takes effect for the sample after the loading edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gain_c0_r <= 16'h4000;
      gain_c1_r <= 16'h4000;
    end else if (i_gain_load) begin
      gain_c0_r <= i_gain_c0;
      gain_c1_r <= i_gain_c1;
    end
  end

  // Pick the shadow gain belonging to the incoming sample's carrier
  always_comb begin
    gain_sel_s = gain_c0_r;
    case (i_data_ca)
      1'b0:    gain_sel_s = gain_c0_r;
      1'b1:    gain_sel_s = gain_c1_r;
      default: gain_sel_s = gain_c0_r;
    endcase
  end

  // Stage 1: capture sample together with its gain; invalid slots carry zeros
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_r  <= 1'b0;
      s1_ca_r   <= 1'b0;
      s1_data_r <= 16'sd0;
      s1_gain_r <= 16'd0;
    end else begin
      s1_vld_r  <= i_data_vld;
      s1_ca_r   <= i_data_vld ? i_data_ca : 1'b0;
      s1_data_r <= i_data_vld ? i_data : 16'sd0;
      s1_gain_r <= i_data_vld ? gain_sel_s : 16'd0;
    end
  end

  // Signed sample times zero-extended gain, both widened to the 33-bit product width
  always_comb begin
    mult_s = $signed({{17{s1_data_r[15]}}, s1_data_r}) * $signed({17'd0, s1_gain_r});
  end

  // Stage 2: register the product
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_vld_r  <= 1'b0;
      s2_ca_r   <= 1'b0;
      s2_prod_r <= 33'sd0;
    end else begin
      s2_vld_r  <= s1_vld_r;
      s2_ca_r   <= s1_ca_r;
      s2_prod_r <= s1_vld_r ? mult_s : 33'sd0;
    end
  end

  // Round half up back to integer scale, then clamp to the signed 16-bit range
  always_comb begin
    round_sum_s = s2_prod_r + 33'sd8192;
    rnd_s       = round_sum_s >>> 14;
    sat_data_s  = rnd_s[15:0];
    sat_s       = 1'b0;
    if (rnd_s > 33'sd32767) begin
      sat_data_s = 16'sh7FFF;
      sat_s      = 1'b1;
    end else if (rnd_s < -33'sd32768) begin
      sat_data_s = 16'sh8000;
      sat_s      = 1'b1;
    end else begin
      sat_data_s = rnd_s[15:0];
      sat_s      = 1'b0;
    end
    sat_hit_s = s2_vld_r & sat_s;
  end

  // Stage 3: registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_vld <= 1'b0;
      o_data_ca  <= 1'b0;
      o_data     <= 16'sd0;
    end else begin
      o_data_vld <= s2_vld_r;
      o_data_ca  <= s2_ca_r;
      o_data     <= s2_vld_r ? sat_data_s : 16'sd0;
    end
  end

  // Saturation event counter; clear wins over increment and the count sticks at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sat_cnt <= {SAT_CNT_W{1'b0}};
    end else if (i_sat_clr) begin
      o_sat_cnt <= {SAT_CNT_W{1'b0}};
    end else if (sat_hit_s && (o_sat_cnt != SAT_MAX)) begin
      o_sat_cnt <= o_sat_cnt + SAT_ONE;
    end
  end

  // Square of the current output and the running sum including it
  always_comb begin
    sq_s       = $signed({{15{o_data[15]}}, o_data}) * $signed({{15{o_data[15]}}, o_data});
    acc_next_s = acc_r + {{WIN_LOG2{1'b0}}, sq_s};
  end

  // Windowed power: accumulate valid output squares, publish the mean when the window fills
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_r     <= {ACC_W{1'b0}};
      win_cnt_r <= {WIN_LOG2{1'b0}};
      o_pwr     <= 32'd0;
      o_pwr_vld <= 1'b0;
    end else begin
      o_pwr_vld <= 1'b0;
      if (o_data_vld) begin
        win_cnt_r <= win_cnt_r + CNT_ONE;
        if (win_cnt_r == CNT_LAST) begin
          o_pwr     <= {1'b0, acc_next_s[ACC_W-1:WIN_LOG2]};
          o_pwr_vld <= 1'b1;
          acc_r     <= {ACC_W{1'b0}};
        end else begin
          acc_r     <= acc_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_duc_gain_sat_491m.sv
// Directed bench for duc_gain_sat_491m with a 4-sample power window.
module tb_duc_gain_sat_491m;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_data_vld;
  logic               i_data_ca;
  logic signed [15:0] i_data;
  logic [15:0]        i_gain_c0;
  logic [15:0]        i_gain_c1;
  logic               i_gain_load;
  logic               i_sat_clr;
  logic               o_data_vld;
  logic               o_data_ca;
  logic signed [15:0] o_data;
  logic [15:0]        o_sat_cnt;
  logic [31:0]        o_pwr;
  logic               o_pwr_vld;

  int errors = 0;
  int checks = 0;
  int pwr_pulses = 0;
  logic [31:0] last_pwr = 32'd0;

  typedef struct {
    string              tag;
    logic               v;
    logic               ca;
    logic signed [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  duc_gain_sat_491m #(.WIN_LOG2(2), .SAT_CNT_W(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data_vld  (i_data_vld),
    .i_data_ca   (i_data_ca),
    .i_data      (i_data),
    .i_gain_c0   (i_gain_c0),
    .i_gain_c1   (i_gain_c1),
    .i_gain_load (i_gain_load),
    .i_sat_clr   (i_sat_clr),
    .o_data_vld  (o_data_vld),
    .o_data_ca   (o_data_ca),
    .o_data      (o_data),
    .o_sat_cnt   (o_sat_cnt),
    .o_pwr       (o_pwr),
    .o_pwr_vld   (o_pwr_vld)
  );

  // 10 ns period sample clock
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; tally power pulses
  task automatic step();
    @(posedge i_clk);
    #1;
    if (o_pwr_vld === 1'b1) begin
      pwr_pulses++;
      last_pwr = o_pwr;
    end
  endtask

  // Apply one input slot and check the output of the slot driven two calls earlier
  task automatic drive(input string tag, input logic v, input logic ca,
                       input logic signed [15:0] d, input logic ld, input logic clr,
                       input logic ev, input logic signed [15:0] ed);
    exp_t e;
    i_data_vld  = v;
    i_data_ca   = ca;
    i_data      = d;
    i_gain_load = ld;
    i_sat_clr   = clr;
    e.tag = tag;
    e.v   = ev;
    e.ca  = ca;
    e.d   = ed;
    exp_q.push_back(e);
    step();
    i_gain_load = 1'b0;
    i_sat_clr   = 1'b0;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check_val({e.tag, " vld"}, {63'd0, o_data_vld}, {63'd0, e.v});
      check_val({e.tag, " data"}, o_data, e.d);
      if (e.v) check_val({e.tag, " ca"}, {63'd0, o_data_ca}, {63'd0, e.ca});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive("idle", 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);
  endtask

  initial begin
    exp_t f;
    i_rst = 1'b1; i_data_vld = 1'b0; i_data_ca = 1'b0; i_data = 16'sd0;
    i_gain_c0 = 16'h4000; i_gain_c1 = 16'h4000; i_gain_load = 1'b0; i_sat_clr = 1'b0;
    step();
    step();
    check_val("rst vld", {63'd0, o_data_vld}, 64'sd0);
    check_val("rst data", o_data, 64'sd0);
    check_val("rst ca", {63'd0, o_data_ca}, 64'sd0);
    check_val("rst sat", {48'd0, o_sat_cnt}, 64'sd0);
    check_val("rst pwr", {32'd0, o_pwr}, 64'sd0);
    check_val("rst pwr_vld", {63'd0, o_pwr_vld}, 64'sd0);
    i_rst = 1'b0;

    // Unity gain
    drive("u1234", 1'b1, 1'b0, 16'sd1234, 1'b0, 1'b0, 1'b1, 16'sd1234);
    drive("um1234", 1'b1, 1'b0, -16'sd1234, 1'b0, 1'b0, 1'b1, -16'sd1234);
    drive("umax", 1'b1, 1'b0, 16'sd32767, 1'b0, 1'b0, 1'b1, 16'sd32767);
    drive("umin", 1'b1, 1'b0, -16'sd32768, 1'b0, 1'b0, 1'b1, -16'sd32768);
    idle(2);
    check_val("unity sat", {48'd0, o_sat_cnt}, 64'sd0);

    // Gain 2.0 with saturation
    i_gain_c0 = 16'h8000;
    drive("ld2", 1'b0, 1'b0, 16'sd0, 1'b1, 1'b0, 1'b0, 16'sd0);
    drive("g2pos", 1'b1, 1'b0, 16'sd20000, 1'b0, 1'b0, 1'b1, 16'sd32767);
    drive("g2neg", 1'b1, 1'b0, -16'sd20000, 1'b0, 1'b0, 1'b1, -16'sd32768);
    drive("g2_100", 1'b1, 1'b0, 16'sd100, 1'b0, 1'b0, 1'b1, 16'sd200);
    idle(2);
    check_val("sat cnt2", {48'd0, o_sat_cnt}, 64'sd2);
    // Clear lands on the same edge as a third saturating sample
    drive("g2sat3", 1'b1, 1'b0, 16'sd20000, 1'b0, 1'b0, 1'b1, 16'sd32767);
    drive("idle", 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);
    drive("clr", 1'b0, 1'b0, 16'sd0, 1'b0, 1'b1, 1'b0, 16'sd0);
    check_val("sat clr prio", {48'd0, o_sat_cnt}, 64'sd0);

    // Rounding and carrier select
    i_gain_c0 = 16'h2000;
    i_gain_c1 = 16'h6000;
    drive("ldr", 1'b0, 1'b0, 16'sd0, 1'b1, 1'b0, 1'b0, 16'sd0);
    drive("r_c0", 1'b1, 1'b0, 16'sd3, 1'b0, 1'b0, 1'b1, 16'sd2);
    drive("r_c1", 1'b1, 1'b1, 16'sd3, 1'b0, 1'b0, 1'b1, 16'sd5);
    drive("r_neg", 1'b1, 1'b0, -16'sd3, 1'b0, 1'b0, 1'b1, -16'sd1);
    idle(2);

    // Load coincident with a sample: that sample keeps the old 0.5 gain
    i_gain_c0 = 16'h4000;
    drive("ldt_old", 1'b1, 1'b0, 16'sd1000, 1'b1, 1'b0, 1'b1, 16'sd500);
    drive("ldt_new", 1'b1, 1'b0, 16'sd1000, 1'b0, 1'b0, 1'b1, 16'sd1000);
    idle(2);

    // Power meter from a clean reset
    i_gain_c1 = 16'h4000;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_q.delete();
    pwr_pulses = 0;
    check_val("pwr after rst", {32'd0, o_pwr}, 64'sd0);
    for (int k = 0; k < 3; k++) begin
      drive("p1000", 1'b1, 1'b0, 16'sd1000, 1'b0, 1'b0, 1'b1, 16'sd1000);
      idle(3);
    end
    check_val("gaps no pulse", pwr_pulses, 64'sd0);
    drive("p1000", 1'b1, 1'b0, 16'sd1000, 1'b0, 1'b0, 1'b1, 16'sd1000);
    idle(3);
    check_val("win1 pulses", pwr_pulses, 64'sd1);
    check_val("win1 pwr", {32'd0, last_pwr}, 64'sd1000000);
    check_val("pwr hold", {32'd0, o_pwr}, 64'sd1000000);

    pwr_pulses = 0;
    drive("pmax", 1'b1, 1'b0, 16'sd32767, 1'b0, 1'b0, 1'b1, 16'sd32767);
    drive("pmin", 1'b1, 1'b0, -16'sd32767, 1'b0, 1'b0, 1'b1, -16'sd32767);
    drive("pmax", 1'b1, 1'b1, 16'sd32767, 1'b0, 1'b0, 1'b1, 16'sd32767);
    drive("pmin", 1'b1, 1'b1, -16'sd32767, 1'b0, 1'b0, 1'b1, -16'sd32767);
    idle(3);
    check_val("win2 pulses", pwr_pulses, 64'sd1);
    check_val("win2 pwr", {32'd0, last_pwr}, 64'sd1073676289);

    // Reset mid-window with a full pipeline
    pwr_pulses = 0;
    drive("m500", 1'b1, 1'b0, 16'sd500, 1'b0, 1'b0, 1'b1, 16'sd500);
    drive("m500", 1'b1, 1'b0, 16'sd500, 1'b0, 1'b0, 1'b1, 16'sd500);
    idle(2);
    drive("m700", 1'b1, 1'b0, 16'sd700, 1'b0, 1'b0, 1'b1, 16'sd700);
    drive("m700", 1'b1, 1'b0, 16'sd700, 1'b0, 1'b0, 1'b1, 16'sd700);
    drive("m700", 1'b1, 1'b0, 16'sd700, 1'b0, 1'b0, 1'b1, 16'sd700);
    i_rst = 1'b1;
    i_data_vld = 1'b0;
    step();
    i_rst = 1'b0;
    check_val("mrst vld", {63'd0, o_data_vld}, 64'sd0);
    check_val("mrst data", o_data, 64'sd0);
    check_val("mrst sat", {48'd0, o_sat_cnt}, 64'sd0);
    check_val("mrst pwr", {32'd0, o_pwr}, 64'sd0);
    check_val("mrst pwr_vld", {63'd0, o_pwr_vld}, 64'sd0);
    // Flushed stages must stay empty after the reset
    exp_q.delete();
    f.tag = "rst_flush"; f.v = 1'b0; f.ca = 1'b0; f.d = 16'sd0;
    exp_q.push_back(f);
    exp_q.push_back(f);
    for (int k = 0; k < 3; k++)
      drive("n100", 1'b1, 1'b0, 16'sd100, 1'b0, 1'b0, 1'b1, 16'sd100);
    idle(3);
    check_val("mrst partial", pwr_pulses, 64'sd0);
    drive("n100", 1'b1, 1'b0, 16'sd100, 1'b0, 1'b0, 1'b1, 16'sd100);
    idle(3);
    check_val("mrst win pulses", pwr_pulses, 64'sd1);
    check_val("mrst win pwr", {32'd0, last_pwr}, 64'sd10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
